// File: rtl/prog_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_if
// Brief    : Config write port (valid/ready) for the programmable divider.
// Revision : 1.0
// ============================================================================
interface prog_clock_divider_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 27
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_half,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_half,
        input  cfg_mode,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Brief    : Multi-channel programmable clock/strobe divider; reloads take
//            effect at each channel's wrap, sync realigns every channel.
// Revision : 1.0
// ============================================================================
module prog_clock_divider #(
    parameter int CHANNELS     = 4,
    parameter int DIV_W        = 27,
    parameter int DEFAULT_HALF = 50000000,
    parameter int CH_W         = 2
) (
    input  wire                 clk_in,
    input  wire                 rst,
    input  wire  [CHANNELS-1:0] en,
    input  wire                 sync,
    prog_clock_divider_if.slave cfg,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    localparam int               NSLOT          = 1 << CH_W;
    localparam logic [DIV_W-1:0] C_DEFAULT_HALF = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] C_ONE          = DIV_W'(1);

    logic [CHANNELS-1:0] w_pend_vec;
    logic [NSLOT-1:0]    w_pend_slot;
    logic                w_cfg_fire;

    // Slots beyond CHANNELS read as idle so out-of-range writes are accepted and dropped.
    always_comb begin
        w_pend_slot                 = '0;
        w_pend_slot[CHANNELS-1:0]   = w_pend_vec;
    end

    assign cfg.cfg_ready = ~w_pend_slot[cfg.cfg_chan];
    assign w_cfg_fire    = cfg.cfg_valid & cfg.cfg_ready;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic [DIV_W-1:0] half_q, half_d;
            logic [DIV_W-1:0] shalf_q, shalf_d;
            logic             phase_q, phase_d;
            logic             mode_q, mode_d;
            logic             smode_q, smode_d;
            logic             pend_q, pend_d;
            logic             tick_q, tick_d;
            logic             out_q, out_d;
            logic             w_accept;
            logic             w_apply;
            logic             w_rise;

            assign w_accept = w_cfg_fire & (cfg.cfg_chan == CH_W'(i));

            always_comb begin
                cnt_d   = cnt_q;
                phase_d = phase_q;
                half_d  = half_q;
                mode_d  = mode_q;
                shalf_d = shalf_q;
                smode_d = smode_q;
                pend_d  = pend_q;
                w_apply = 1'b0;

                if (sync || !en[i]) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    w_apply = pend_q;
                end else if (cnt_q == half_q - C_ONE) begin
                    // Wrap finishes on the old H; the reload governs the next half-period.
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    w_apply = pend_q;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end

                if (w_apply) begin
                    half_d = shalf_q;
                    mode_d = smode_q;
                    pend_d = 1'b0;
                end

                if (w_accept) begin
                    shalf_d = (cfg.cfg_half == '0) ? C_ONE : cfg.cfg_half;
                    smode_d = cfg.cfg_mode;
                    pend_d  = 1'b1;
                end

                w_rise = phase_d & ~phase_q;
                tick_d = w_rise;
                out_d  = mode_d ? w_rise : phase_d;
            end

            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    cnt_q   <= '0;
                    phase_q <= 1'b0;
                    half_q  <= C_DEFAULT_HALF;
                    mode_q  <= 1'b0;
                    shalf_q <= '0;
                    smode_q <= 1'b0;
                    pend_q  <= 1'b0;
                    tick_q  <= 1'b0;
                    out_q   <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    phase_q <= phase_d;
                    half_q  <= half_d;
                    mode_q  <= mode_d;
                    shalf_q <= shalf_d;
                    smode_q <= smode_d;
                    pend_q  <= pend_d;
                    tick_q  <= tick_d;
                    out_q   <= out_d;
                end
            end

            assign clk_out[i]    = out_q;
            assign tick[i]       = tick_q;
            assign w_pend_vec[i] = pend_q;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clock_divider
// Brief    : Directed scoreboard bench for prog_clock_divider (4 ch, H=3 default).
// Revision : 1.0
// ============================================================================
module tb_prog_clock_divider;
    localparam int CHANNELS     = 4;
    localparam int DIV_W        = 8;
    localparam int DEFAULT_HALF = 3;
    localparam int CH_W         = 2;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] tick;

    prog_clock_divider_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg ();

    prog_clock_divider #(
        .CHANNELS    (CHANNELS),
        .DIV_W       (DIV_W),
        .DEFAULT_HALF(DEFAULT_HALF),
        .CH_W        (CH_W)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .cfg    (cfg),
        .clk_out(clk_out),
        .tick   (tick)
    );

    always #5 clk_in = ~clk_in;

    // Expected {ready, tick, clk_out} for the next sample point, with a label.
    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic push_exp(input logic [3:0] eclk, input logic [3:0] etck,
                            input logic erdy, input string nm);
        exp_q.push_back({erdy, etck, eclk});
        name_q.push_back(nm);
    endtask

    task automatic step(input logic [3:0] eclk, input logic [3:0] etck,
                        input logic erdy, input string nm);
        push_exp(eclk, etck, erdy, nm);
        @(posedge clk_in);
        #3;
    endtask

    initial begin : monitor
        logic [8:0] e;
        string      nm;
        forever begin
            @(posedge clk_in or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if ({cfg.cfg_ready, tick, clk_out} !== e) begin
                    n_err++;
                    $display("FAIL %s: ready/tick/clk_out got %b/%b/%b, want %b/%b/%b",
                             nm, cfg.cfg_ready, tick, clk_out, e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] ec, et;
        logic [3:0] s5_clk [6];
        logic [3:0] s5_tck [6];

        rst           = 1'b1;
        en            = '0;
        sync          = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_chan  = '0;
        cfg.cfg_half  = '0;
        cfg.cfg_mode  = 1'b0;
        #2;

        step(4'b0000, 4'b0000, 1'b1, "reset_hold");
        step(4'b0000, 4'b0000, 1'b1, "reset_hold");

        // Ch0 with default H=3: rises at 3rd edge, period 6
        rst = 1'b0;
        en  = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            ec = '0; et = '0;
            ec[0] = ((k / 3) % 2) == 1;
            et[0] = (k % 6) == 3;
            step(ec, et, 1'b1, "s1_ch0_default");
        end

        // Reload ch0 to H=5 while cnt=1
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = 2'd0;
        cfg.cfg_half  = 8'd5;
        cfg.cfg_mode  = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, "s2_accept_busy");
        cfg.cfg_valid = 1'b0;
        for (int j = 0; j < 12; j++) begin
            ec = '0; et = '0;
            ec[0] = ((j / 5) % 2) == 0;
            et[0] = (j % 10) == 0;
            step(ec, et, 1'b1, "s2_reload_h5");
        end

        // Ch2 with cfg_half=0 -> H=1
        en            = 4'b0000;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = 2'd2;
        cfg.cfg_half  = 8'd0;
        step(4'b0000, 4'b0000, 1'b0, "s3_accept");
        cfg.cfg_valid = 1'b0;
        step(4'b0000, 4'b0000, 1'b1, "s3_apply_disabled");
        en = 4'b0100;
        for (int j = 0; j < 6; j++) begin
            ec = '0; et = '0;
            ec[2] = (j % 2) == 0;
            et[2] = (j % 2) == 0;
            step(ec, et, 1'b1, "s3_half_zero");
        end

        // Ch1 pulse mode H=2
        en            = 4'b0000;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = 2'd1;
        cfg.cfg_half  = 8'd2;
        cfg.cfg_mode  = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, "s4_accept");
        cfg.cfg_valid = 1'b0;
        cfg.cfg_mode  = 1'b0;
        step(4'b0000, 4'b0000, 1'b1, "s4_apply");
        en = 4'b0010;
        for (int m = 1; m <= 10; m++) begin
            ec = '0; et = '0;
            ec[1] = (m % 4) == 2;
            et[1] = (m % 4) == 2;
            step(ec, et, 1'b1, "s4_pulse");
        end

        // Back-to-back configs: ch0 H=3, ch3 H=5
        en            = 4'b0000;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = 2'd0;
        cfg.cfg_half  = 8'd3;
        cfg.cfg_mode  = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, "s5_accept_ch0");
        cfg.cfg_chan  = 2'd3;
        cfg.cfg_half  = 8'd5;
        step(4'b0000, 4'b0000, 1'b0, "s5_accept_ch3");
        cfg.cfg_valid = 1'b0;
        step(4'b0000, 4'b0000, 1'b1, "s5_apply_ch3");

        en = 4'b0001;
        step(4'b0000, 4'b0000, 1'b1, "s5_ch0_lead");
        en = 4'b1001;
        s5_clk = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
        s5_tck = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        for (int g = 0; g < 6; g++) begin
            step(s5_clk[g], s5_tck[g], 1'b1, "s5_out_of_phase");
        end

        sync = 1'b1;
        step(4'b0000, 4'b0000, 1'b1, "s5_sync");
        sync = 1'b0;
        for (int n = 1; n <= 46; n++) begin
            ec = '0; et = '0;
            ec[0] = ((n / 3) % 2) == 1;
            et[0] = (n % 6) == 3;
            ec[3] = ((n / 5) % 2) == 1;
            et[3] = (n % 10) == 5;
            step(ec, et, 1'b1, "s5_after_sync");
        end

        // Pending config on ch3 lost by a mid-cycle async reset
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = 2'd3;
        cfg.cfg_half  = 8'd7;
        cfg.cfg_mode  = 1'b1;
        step(4'b1001, 4'b0000, 1'b0, "s6_accept_pending");
        cfg.cfg_valid = 1'b0;
        cfg.cfg_mode  = 1'b0;
        #2;
        push_exp(4'b0000, 4'b0000, 1'b1, "s6_async_reset");
        rst = 1'b1;
        step(4'b0000, 4'b0000, 1'b1, "s6_reset_hold");
        step(4'b0000, 4'b0000, 1'b1, "s6_reset_hold");
        rst = 1'b0;
        en  = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            ec = {4{((k / 3) % 2) == 1}};
            et = {4{(k % 6) == 3}};
            step(ec, et, 1'b1, "s6_defaults");
        end

        @(posedge clk_in);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
